// File: rtl/keypad_entry.sv
// Keypad key-event filter and BCD entry buffer with backspace/clear/enter.
// Optional idle auto-clear: define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_entry #(
  parameter int          DIGITS         = 4,
  parameter int          COUNT_W        = 3,
  parameter int          RELEASE_CYCLES = 8,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key,
  input  logic                  pressed,
  output logic [4*DIGITS-1:0]   entry,
  output logic [COUNT_W-1:0]    count,
  output logic [4*DIGITS-1:0]   commit_value,
  output logic                  commit_valid,
  output logic                  key_accepted,
  output logic                  overflow,
  output logic                  timeout
);

  localparam int EW   = 4 * DIGITS;
  localparam int RC_W = $clog2(RELEASE_CYCLES);

  localparam logic [0:0] WAIT_PRESS   = 1'b0;
  localparam logic [0:0] WAIT_RELEASE = 1'b1;

  localparam logic [RC_W-1:0]    RC_LAST = RC_W'(RELEASE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] FULL    = COUNT_W'(DIGITS);
  localparam logic [COUNT_W-1:0] C_ONE   = COUNT_W'(1);

  logic [0:0]         r_state;
  logic [RC_W-1:0]    r_rel;
  logic [EW-1:0]      r_entry;
  logic [COUNT_W-1:0] r_count;
  logic [EW-1:0]      r_cval;
  logic               r_cv;
  logic               r_acc;
  logic               r_ovf;
  logic               r_to;

  logic [EW-1:0]      w_entry_n;
  logic [COUNT_W-1:0] w_count_n;
  logic               w_ovf_n;
  logic               w_commit;
  logic               w_is_digit;
  logic               w_accept;
  logic               w_to_hit;

  assign w_is_digit = (key <= 4'd9);
  assign w_accept   = (r_state == WAIT_PRESS) && pressed;

  always_comb begin
    w_entry_n = r_entry;
    w_count_n = r_count;
    w_ovf_n   = r_ovf;
    w_commit  = 1'b0;
    unique case (1'b1)
      w_is_digit: begin
        if (r_count == FULL) begin
          w_ovf_n = 1'b1;
        end else begin
          w_entry_n = {r_entry[EW-5:0], key};
          w_count_n = r_count + C_ONE;
        end
      end
      (key == 4'hA): begin
        w_ovf_n = 1'b0;
        if (r_count != '0) begin
          w_entry_n = r_entry >> 4;
          w_count_n = r_count - C_ONE;
        end
      end
      (key == 4'hB): begin
        w_entry_n = '0;
        w_count_n = '0;
        w_ovf_n   = 1'b0;
      end
      (key == 4'hE): begin
        if (r_count != '0) begin
          w_commit  = 1'b1;
          w_entry_n = '0;
          w_count_n = '0;
          w_ovf_n   = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = TIMEOUT_CYCLES - 24'd1;

  logic [23:0] r_tmo;

  assign w_to_hit = (r_state == WAIT_PRESS) && (r_count != '0)
                    && (r_tmo == TO_LAST);

  // Held at zero through the release wait; only idle WAIT_PRESS time counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_accept || r_count == '0 || w_to_hit) begin
      r_tmo <= '0;
    end else if (r_state == WAIT_PRESS) begin
      r_tmo <= r_tmo + 24'd1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = ^TIMEOUT_CYCLES;
  assign w_to_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_PRESS;
      r_rel   <= '0;
      r_entry <= '0;
      r_count <= '0;
      r_cval  <= '0;
      r_cv    <= 1'b0;
      r_acc   <= 1'b0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_cv  <= 1'b0;
      r_acc <= 1'b0;
      r_to  <= 1'b0;
      unique case (r_state)
        WAIT_PRESS: begin
          if (pressed) begin
            r_state <= WAIT_RELEASE;
            r_rel   <= '0;
            r_acc   <= 1'b1;
            r_entry <= w_entry_n;
            r_count <= w_count_n;
            r_ovf   <= w_ovf_n;
            if (w_commit) begin
              r_cval <= r_entry;
              r_cv   <= 1'b1;
            end
          end else if (w_to_hit) begin
            r_entry <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_to    <= 1'b1;
          end
        end
        WAIT_RELEASE: begin
          // Scanner drops pressed between row sweeps; demand a full quiet run.
          if (pressed) begin
            r_rel <= '0;
          end else if (r_rel == RC_LAST) begin
            r_rel   <= '0;
            r_state <= WAIT_PRESS;
          end else begin
            r_rel <= r_rel + 1'b1;
          end
        end
        default: r_state <= WAIT_PRESS;
      endcase
    end
  end

  assign entry        = r_entry;
  assign count        = r_count;
  assign commit_value = r_cval;
  assign commit_valid = r_cv;
  assign key_accepted = r_acc;
  assign overflow     = r_ovf;
  assign timeout      = r_to;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: expected state queued per key press,
// checked by a monitor on each key_accepted pulse.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  key = 4'h0;
  logic        pressed = 1'b0;
  logic [15:0] entry;
  logic [2:0]  count;
  logic [15:0] commit_value;
  logic        commit_valid;
  logic        key_accepted;
  logic        overflow;
  logic        timeout;

  keypad_entry #(
    .DIGITS(4),
    .COUNT_W(3),
    .RELEASE_CYCLES(8),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .pressed(pressed),
    .entry(entry),
    .count(count),
    .commit_value(commit_value),
    .commit_valid(commit_valid),
    .key_accepted(key_accepted),
    .overflow(overflow),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] e;
    logic [2:0]  c;
    logic        o;
    logic        cv;
    logic [15:0] cval;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_to   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_accepted) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL accept: got unexpected key_accepted at %0t", $time);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("entry", 32'(entry), 32'(x.e));
          chk("count", 32'(count), 32'(x.c));
          chk("overflow", 32'(overflow), 32'(x.o));
          chk("commit_valid", 32'(commit_valid), 32'(x.cv));
          chk("commit_value", 32'(commit_value), 32'(x.cval));
        end
      end else begin
        chk("commit_valid_idle", 32'(commit_valid), 32'd0);
      end
      if (timeout) n_to++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold, input bit gaps,
                       input logic [15:0] e, input logic [2:0] c,
                       input bit o, input bit cv, input logic [15:0] cval);
    sb.push_back('{e: e, c: c, o: o, cv: cv, cval: cval});
    key = k;
    for (int i = 0; i < hold; i++) begin
      pressed = gaps ? (i % 4 == 0) : 1'b1;
      step();
    end
    pressed = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_entry"}, 32'(entry), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_cval"}, 32'(commit_value), 32'd0);
    chk({tag, "_cv"}, 32'(commit_valid), 32'd0);
    chk({tag, "_acc"}, 32'(key_accepted), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_to"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // held key with scanner gaps: one event only
    press(4'h1, 20, 1'b1, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0);
    chk("sb_drain_hold", 32'(sb.size()), 32'd0);

    press(4'hB, 3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0);
    press(4'h1, 3, 1'b0, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0);
    press(4'h2, 3, 1'b0, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h0);
    press(4'h3, 3, 1'b0, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h0);
    press(4'h4, 3, 1'b0, 16'h1234, 3'd4, 1'b0, 1'b0, 16'h0);
    press(4'h5, 3, 1'b0, 16'h1234, 3'd4, 1'b1, 1'b0, 16'h0);
    press(4'hA, 3, 1'b0, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h0);

    press(4'hB, 3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0);
    press(4'h7, 3, 1'b0, 16'h0007, 3'd1, 1'b0, 1'b0, 16'h0);
    press(4'h8, 3, 1'b0, 16'h0078, 3'd2, 1'b0, 1'b0, 16'h0);
    press(4'hE, 3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0078);
    press(4'hE, 3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0078);

    press(4'h9, 3, 1'b0, 16'h0009, 3'd1, 1'b0, 1'b0, 16'h0078);
    press(4'hB, 3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0078);
    press(4'hA, 3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0078);
    press(4'hC, 3, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0078);
    press(4'h5, 3, 1'b0, 16'h0005, 3'd1, 1'b0, 1'b0, 16'h0078);
    press(4'hD, 3, 1'b0, 16'h0005, 3'd1, 1'b0, 1'b0, 16'h0078);
    press(4'hF, 3, 1'b0, 16'h0005, 3'd1, 1'b0, 1'b0, 16'h0078);
    chk("sb_drain_cmds", 32'(sb.size()), 32'd0);

    // reset asserted while the release wait is in progress
    sb.push_back('{e: 16'h0055, c: 3'd2, o: 1'b0, cv: 1'b0, cval: 16'h0078});
    key = 4'h5;
    pressed = 1'b1;
    step();
    step();
    pressed = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("sb_drain_midrst", 32'(sb.size()), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    press(4'h3, 3, 1'b0, 16'h0003, 3'd1, 1'b0, 1'b0, 16'h0);
    n_to = 0;
    for (int i = 0; i < 150; i++) step();
    chk("sb_drain_final", 32'(sb.size()), 32'd0);
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    chk("timeout_pulses", 32'(n_to), 32'd1);
    chk("timeout_entry", 32'(entry), 32'h0000);
    chk("timeout_count", 32'(count), 32'd0);
`else
    chk("timeout_pulses", 32'(n_to), 32'd0);
    chk("idle_entry", 32'(entry), 32'h0003);
    chk("idle_count", 32'(count), 32'd1);
`endif
    chk("idle_cval", 32'(commit_value), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
